// File: rtl/cic_interpolator.sv
// CIC interpolation filter: N comb stages at the input rate, zero-stuffing by
// R = 2**RATE_LOG2, N registered integrator stages at the output rate.
module cic_interpolator #(
  parameter int  IN_WIDTH  = 16,
  parameter int  N_STAGES  = 3,
  parameter int  RATE_LOG2 = 3,
  localparam int OUT_WIDTH = IN_WIDTH + (N_STAGES - 1) * RATE_LOG2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic signed [IN_WIDTH-1:0]  in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic signed [OUT_WIDTH-1:0] out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [RATE_LOG2-1:0]        PHASE_FIRST = RATE_LOG2'(0);
  localparam logic [RATE_LOG2-1:0]        PHASE_LAST  = {RATE_LOG2{1'b1}};
  localparam logic [RATE_LOG2-1:0]        PHASE_STEP  = RATE_LOG2'(1);
  localparam logic signed [OUT_WIDTH-1:0] ZERO        = {OUT_WIDTH{1'b0}};

  state_t                      state_r;
  logic [RATE_LOG2-1:0]        phase_r;
  logic signed [OUT_WIDTH-1:0] dly_r       [N_STAGES];
  logic signed [OUT_WIDTH-1:0] comb_tap_s  [N_STAGES];
  logic signed [OUT_WIDTH-1:0] integ_r     [N_STAGES];
  logic signed [OUT_WIDTH-1:0] integ_nxt_s [N_STAGES];
  logic signed [OUT_WIDTH-1:0] comb_out_s;
  logic signed [OUT_WIDTH-1:0] comb_q_r;
  logic signed [OUT_WIDTH-1:0] u_s;
  logic                        adv_s;
  logic                        acc_s;
  logic                        last_s;

  // Handshake decode; in_ready_o deliberately sees out_ready_i combinationally
  always_comb begin
    adv_s  = !out_valid_o || out_ready_i;
    last_s = (phase_r == PHASE_LAST);
    if (state_r == ST_IDLE) begin
      in_ready_o = 1'b1;
    end else if (state_r == ST_EMIT) begin
      in_ready_o = last_s && adv_s;
    end else begin
      in_ready_o = 1'b0;
    end
    acc_s = in_valid_i && in_ready_o;
  end

  // Comb cascade: each stage subtracts its own delayed input
  always_comb begin
    logic signed [OUT_WIDTH-1:0] c_v;
    c_v = OUT_WIDTH'($signed(in_data_i));
    for (int k = 0; k < N_STAGES; k++) begin
      comb_tap_s[k] = c_v;
      c_v           = c_v - dly_r[k];
    end
    comb_out_s = c_v;
  end

  // Integrator next values; the cascade uses pre-update values of the previous stage
  always_comb begin
    if (phase_r == PHASE_FIRST) begin
      u_s = comb_q_r;
    end else begin
      u_s = ZERO;
    end
    integ_nxt_s[0] = integ_r[0] + u_s;
    for (int k = 1; k < N_STAGES; k++) begin
      integ_nxt_s[k] = integ_r[k] + integ_r[k-1];
    end
  end

  // Comb delay line and comb output register, advanced only on accepted input
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < N_STAGES; k++) begin
        dly_r[k] <= ZERO;
      end
      comb_q_r <= ZERO;
    end else if (acc_s) begin
      for (int k = 0; k < N_STAGES; k++) begin
        dly_r[k] <= comb_tap_s[k];
      end
      comb_q_r <= comb_out_s;
    end
  end

  // Emission FSM: phase counter, integrator cascade and registered output
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      phase_r     <= PHASE_FIRST;
      out_data_o  <= ZERO;
      out_valid_o <= 1'b0;
      for (int k = 0; k < N_STAGES; k++) begin
        integ_r[k] <= ZERO;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (adv_s) begin
            out_valid_o <= 1'b0;
          end
          if (acc_s) begin
            state_r <= ST_EMIT;
            phase_r <= PHASE_FIRST;
          end
        end
        ST_EMIT: begin
          if (adv_s) begin
            for (int k = 0; k < N_STAGES; k++) begin
              integ_r[k] <= integ_nxt_s[k];
            end
            out_data_o  <= integ_nxt_s[N_STAGES-1];
            out_valid_o <= 1'b1;
            if (last_s) begin
              // comb_q_r is only read at phase 0, so a new sample may land now
              phase_r <= PHASE_FIRST;
              if (!acc_s) begin
                state_r <= ST_IDLE;
              end
            end else begin
              phase_r <= phase_r + PHASE_STEP;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          phase_r <= PHASE_FIRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator: spec vectors on a small instance,
// and a queue-based arithmetic reference model for the default instance.
module tb_cic_interpolator;

  typedef longint lq_t[$];
  typedef int     iq_t[$];

  typedef struct {
    bit     rst;
    longint din;
    longint e0;
    longint e1;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic signed [7:0]  s_in_data   = 8'sd0;
  logic               s_in_valid  = 1'b0;
  logic               s_in_ready;
  logic signed [8:0]  s_out_data;
  logic               s_out_valid;
  logic               s_out_ready = 1'b1;

  logic signed [15:0] d_in_data   = 16'sd0;
  logic               d_in_valid  = 1'b0;
  logic               d_in_ready;
  logic signed [21:0] d_out_data;
  logic               d_out_valid;
  logic               d_out_ready = 1'b1;

  int  n_cmp  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  lq_t s_beats;
  iq_t s_bcyc;
  lq_t d_beats;
  iq_t d_bcyc;

  bit     feed_done  = 1'b0;
  bit     stall_prev = 1'b0;
  longint data_prev  = 64'sd0;

  cic_interpolator #(.IN_WIDTH(8), .N_STAGES(2), .RATE_LOG2(1)) dut_s (
    .clk_i(clk), .reset_i(reset),
    .in_data_i(s_in_data), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .out_data_o(s_out_data), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready)
  );

  cic_interpolator dut_d (
    .clk_i(clk), .reset_i(reset),
    .in_data_i(d_in_data), .in_valid_i(d_in_valid), .in_ready_o(d_in_ready),
    .out_data_o(d_out_data), .out_valid_o(d_out_valid), .out_ready_i(d_out_ready)
  );

  always #5 clk = ~clk;

  // Beat capture at the falling edge: a beat transfers on the following rising edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset && s_out_valid && s_out_ready) begin
      s_beats.push_back(longint'(s_out_data));
      s_bcyc.push_back(cyc);
    end
    if (!reset && d_out_valid && d_out_ready) begin
      d_beats.push_back(longint'(d_out_data));
      d_bcyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Textbook CIC: N differences, zero-stuff, N running sums, then N-1 beats of delay
  function automatic lq_t cic_model(input lq_t x, input int n, input int r, input int w);
    lq_t    y;
    lq_t    u;
    lq_t    o;
    longint m;
    longint v;
    y = x;
    for (int s = 0; s < n; s++)
      for (int i = y.size() - 1; i > 0; i--) y[i] = y[i] - y[i-1];
    for (int i = 0; i < y.size(); i++) begin
      u.push_back(y[i]);
      for (int k = 1; k < r; k++) u.push_back(64'sd0);
    end
    for (int s = 0; s < n; s++)
      for (int i = 1; i < u.size(); i++) u[i] = u[i] + u[i-1];
    m = longint'(1) << w;
    for (int i = 0; i < u.size(); i++) begin
      v = (i >= n - 1) ? u[i-n+1] : 64'sd0;
      v = ((v % m) + m) % m;
      if (v >= m / 2) v = v - m;
      o.push_back(v);
    end
    return o;
  endfunction

  task automatic do_reset();
    s_in_valid = 1'b0;
    d_in_valid = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_s(input longint v);
    int t = 0;
    s_in_data  = 8'(v);
    s_in_valid = 1'b1;
    @(negedge clk);
    while (!s_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("s_accept", longint'(s_in_ready), 64'sd1);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
  endtask

  task automatic send_d(input longint v);
    int t = 0;
    d_in_data  = 16'(v);
    d_in_valid = 1'b1;
    @(negedge clk);
    while (!d_in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("d_accept", longint'(d_in_ready), 64'sd1);
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
  endtask

  task automatic cmp_s(input string tag, input int base, input lq_t exp);
    int t = 0;
    while (s_beats.size() < base + exp.size() && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_count"}, longint'(s_beats.size() - base), longint'(exp.size()));
    for (int j = 0; j < exp.size() && base + j < s_beats.size(); j++)
      check($sformatf("%s[%0d]", tag, j), s_beats[base+j], exp[j]);
  endtask

  task automatic cmp_d(input string tag, input int base, input lq_t exp);
    int t = 0;
    while (d_beats.size() < base + exp.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_count"}, longint'(d_beats.size() - base), longint'(exp.size()));
    for (int j = 0; j < exp.size() && base + j < d_beats.size(); j++)
      check($sformatf("%s[%0d]", tag, j), d_beats[base+j], exp[j]);
  endtask

  // One backpressure cycle: verify stall behaviour, then pick a new out_ready
  task automatic bp_cycle();
    @(negedge clk);
    if (stall_prev) begin
      check("stall_data", longint'(d_out_data), data_prev);
      check("stall_valid", longint'(d_out_valid), 64'sd1);
    end
    if (d_out_valid && !d_out_ready && d_in_valid)
      check("stall_in_ready", longint'(d_in_ready), 64'sd0);
    stall_prev = d_out_valid && !d_out_ready;
    data_prev  = longint'(d_out_data);
    @(posedge clk);
    #1;
    d_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    vec_t vecs [8];
    lq_t  expq;
    lq_t  xs;
    iq_t  accs;
    int   base;
    int   t;

    vecs[0] = '{1'b1, 64'sd1, 64'sd0, 64'sd1};
    vecs[1] = '{1'b0, 64'sd1, 64'sd2, 64'sd2};
    vecs[2] = '{1'b0, 64'sd1, 64'sd2, 64'sd2};
    vecs[3] = '{1'b0, 64'sd1, 64'sd2, 64'sd2};
    vecs[4] = '{1'b1, 64'sd1, 64'sd0, 64'sd1};
    vecs[5] = '{1'b0, 64'sd0, 64'sd2, 64'sd1};
    vecs[6] = '{1'b0, 64'sd0, 64'sd0, 64'sd0};
    vecs[7] = '{1'b0, 64'sd0, 64'sd0, 64'sd0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_out_valid", longint'(s_out_valid), 64'sd0);
    check("rst_s_out_data", longint'(s_out_data), 64'sd0);
    check("rst_s_in_ready", longint'(s_in_ready), 64'sd1);
    check("rst_d_out_valid", longint'(d_out_valid), 64'sd0);
    check("rst_d_out_data", longint'(d_out_data), 64'sd0);
    check("rst_d_in_ready", longint'(d_in_ready), 64'sd1);
    reset = 1'b0;

    // Step and impulse vectors on the N=2, R=2 instance
    base = 0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) begin
        do_reset();
        base = s_beats.size();
        expq = {};
      end
      send_s(vecs[i].din);
      expq.push_back(vecs[i].e0);
      expq.push_back(vecs[i].e1);
      if (i == 7 || vecs[(i == 7) ? 7 : i + 1].rst) begin
        cmp_s($sformatf("vec_grp%0d", i / 4), base, expq);
        if (s_bcyc.size() >= base + expq.size())
          check($sformatf("vec_grp%0d_gap", i / 4),
                longint'(s_bcyc[base+expq.size()-1] - s_bcyc[base]),
                longint'(expq.size() - 1));
      end
    end

    // Full scale positive and negative on the default instance
    do_reset();
    base = d_beats.size();
    xs = {};
    for (int i = 0; i < 8; i++) xs.push_back(64'sd32767);
    for (int i = 0; i < 8; i++) send_d(xs[i]);
    expq = cic_model(xs, 3, 8, 22);
    cmp_d("fs_pos", base, expq);
    check("fs_pos_settled", d_beats[d_beats.size()-1], 64'sd2097088);

    do_reset();
    base = d_beats.size();
    xs = {};
    for (int i = 0; i < 8; i++) xs.push_back(-64'sd32768);
    for (int i = 0; i < 8; i++) send_d(xs[i]);
    expq = cic_model(xs, 3, 8, 22);
    cmp_d("fs_neg", base, expq);
    check("fs_neg_settled", d_beats[d_beats.size()-1], -64'sd2097152);

    // Random samples, first with out_ready held high
    xs = {};
    for (int i = 0; i < 12; i++)
      xs.push_back(longint'($urandom_range(0, 65535)) - 64'sd32768);
    expq = cic_model(xs, 3, 8, 22);
    do_reset();
    base = d_beats.size();
    for (int i = 0; i < 12; i++) send_d(xs[i]);
    cmp_d("rand_nobp", base, expq);

    // Same samples under random backpressure
    do_reset();
    base       = d_beats.size();
    feed_done  = 1'b0;
    stall_prev = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_d(xs[i]);
        feed_done = 1'b1;
      end
      begin
        while (!feed_done) bp_cycle();
      end
    join
    t = 0;
    while (d_beats.size() < base + expq.size() && t < 2000) begin
      bp_cycle();
      t++;
    end
    d_out_ready = 1'b1;
    stall_prev  = 1'b0;
    cmp_d("rand_bp", base, expq);

    // Throughput: continuous input, continuous output
    do_reset();
    base       = d_beats.size();
    accs       = {};
    d_in_data  = 16'sd100;
    d_in_valid = 1'b1;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (d_in_ready) accs.push_back(c);
      @(posedge clk);
      #1;
    end
    d_in_valid = 1'b0;
    for (int k = 1; k < accs.size(); k++)
      check($sformatf("tput_spacing%0d", k), longint'(accs[k] - accs[k-1]), 64'sd8);
    xs = {};
    for (int k = 0; k < accs.size(); k++) xs.push_back(64'sd100);
    expq = cic_model(xs, 3, 8, 22);
    cmp_d("tput", base, expq);
    if (d_bcyc.size() >= base + expq.size())
      check("tput_gap", longint'(d_bcyc[base+expq.size()-1] - d_bcyc[base]),
            longint'(expq.size() - 1));

    // Reset asserted at phase 3 of a sample
    do_reset();
    send_d(64'sd5);
    repeat (3) @(posedge clk);
    #2;
    check("mid_valid_before", longint'(d_out_valid), 64'sd1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", longint'(d_out_valid), 64'sd0);
    check("mid_rst_out_data", longint'(d_out_data), 64'sd0);
    check("mid_rst_in_ready", longint'(d_in_ready), 64'sd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = d_beats.size();
    xs = {};
    for (int i = 0; i < 4; i++) xs.push_back(64'sd1000);
    for (int i = 0; i < 4; i++) send_d(xs[i]);
    expq = cic_model(xs, 3, 8, 22);
    cmp_d("post_rst_step", base, expq);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Multi-stage CIC interpolation filter: N cascaded comb stages at the input rate, zero-stuffing by R = 2^RATE_LOG2, and N cascaded integrator stages at the output rate. It sits on the transmit/upsampling side of the CIC filter library, as the counterpart of the CIC decimation chain built from the comb and integrator stages. Input and output use valid/ready handshakes. One accepted input sample produces exactly R output beats.

## Interface
- IN_WIDTH, 16, signed input sample width.
- N_STAGES, 3, number of comb stages and integrator stages (>=1).
- RATE_LOG2, 3, log2 of interpolation ratio R (>=1, so R>=2).
- OUT_WIDTH (localparam), IN_WIDTH + (N_STAGES-1)*RATE_LOG2; output and internal register width.
- clk_i  input  1  clock; everything is rising-edge.
- reset_i  input  1  reset, asynchronous, active-high.
- in_data_i  input  IN_WIDTH  signed input sample.
- in_valid_i  input  1  input sample valid.
- in_ready_o  output  1  block accepts input this cycle.
- out_data_o  output  OUT_WIDTH  signed interpolated sample.
- out_valid_o  output  1  out_data_o valid.
- out_ready_i  input  1  downstream accepts output this cycle.

## Operation
- Reset, asynchronous, active-high; clock clk_i. Reset clears all comb delay registers, comb_q, integrators, phase counter and state. Reset values: out_data_o=0, out_valid_o=0, in_ready_o=1, state IDLE.
- Arithmetic: in_data_i is sign-extended to OUT_WIDTH. All comb, integrator and output registers are OUT_WIDTH wide, two's complement, and wrap modulo 2^OUT_WIDTH without saturation. The final output is exact because the true gain R^(N-1) fits in OUT_WIDTH.
- Advance enable: adv = !out_valid_o || out_ready_i.
- Input accept: acc = in_valid_i && in_ready_o.
  - in_ready_o = (state==IDLE) || (state==EMIT && phase==R-1 && adv).
  - This is a combinational path from out_ready_i to in_ready_o, and it is intended.
- Comb chain, on acc only:
  - c0 = sext(in_data_i); ck = c(k-1) - d(k), where d(k) is that stage's delay register. The N subtractors are cascaded combinationally.
  - Each d(k) loads c(k-1). comb_q loads cN.
- States:
  - IDLE: no pending sample. acc -> EMIT with phase=0.
  - EMIT: while adv, issue one beat per cycle and increment phase.
    - At phase==R-1 with adv: acc -> EMIT with phase=0 (back-to-back samples); no acc -> IDLE.
    - While !adv: hold phase, state and all registers.
- Integrator step, only on an issued beat (EMIT && adv):
  - u = comb_q if phase==0, else 0.
  - I1 <= I1 + u; Ik <= Ik + I(k-1), using pre-update values (registered cascade).
  - out_data_o <= IN after update, i.e. out_data_o is the IN register. out_valid_o <= 1.
- Idle output: in IDLE with adv, out_valid_o <= 0; integrators and out_data_o hold.
- comb_q is read only at phase 0, so overwriting it at phase R-1 is safe.
- The integrator cascade adds a pure delay of N-1 output beats relative to the textbook CIC response.

## Timing
- Sample accepted in cycle t (acc high at edge t): its first beat is issued in cycle t+1, and out_valid_o is first high in cycle t+2.
- Sustained throughput: one output beat per clock while out_ready_i=1 and in_valid_i is presented at phase R-1. One input is accepted every R cycles.
- Backpressure (out_valid_o=1, out_ready_i=0): out_data_o, out_valid_o, phase and integrators hold, and in_ready_o=0 in EMIT.
- Reset asserted mid-EMIT: outputs return to reset values immediately. Any partially emitted sample is discarded, and filter history is cleared.
- Simultaneous acc and final beat at phase R-1: both take effect on the same edge.

## Test plan
- Step response, N_STAGES=2, RATE_LOG2=1, IN_WIDTH=8, constant input 1, out_ready_i=1 -> output beats 0,1,2,2,2,... with no valid gaps after the first.
- Impulse, same params, input 1 followed by zeros -> beats 0,1,2,1,0,0,...
- Full scale, defaults: constant 32767 -> settles at 2097088; constant -32768 -> settles at -2097152; no wrap on the settled output.
- Random backpressure on out_ready_i with random input samples -> beat sequence identical to the out_ready_i=1 run. out_data_o is stable while stalled, and in_ready_o=0 during stalls.
- Throughput, defaults, in_valid_i=1 and out_ready_i=1 -> in_ready_o pulses every 8 cycles and out_valid_o stays continuously high after the first beat.
- Reset asserted at phase 3 of a sample -> out_valid_o=0 and out_data_o=0 immediately, in_ready_o=1. The next step input reproduces the step-response test from the start.
